// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces two active-low push-buttons,
// produces clean levels, press/release pulses, a chord pulse and a shared
// prescaler tick. Optional long-press detection is built only when the macro
// BUTTON_CONDITIONER_LONGPRESS_EN is defined; otherwise BTN_LONG is tied to 0.
module button_conditioner #(
  parameter int unsigned TICK_DIV     = 4096,
  parameter int unsigned STABLE_TICKS = 240
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  ,
  parameter int unsigned LONG_TICKS   = 24414
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BUT1,
  input  logic       BUT2,
  output logic       TICK,
  output logic [1:0] BTN_LVL,
  output logic [1:0] BTN_PRESS,
  output logic [1:0] BTN_REL,
  output logic       CHORD,
  output logic [1:0] BTN_LONG
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W    = $clog2(STABLE_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(STABLE_TICKS - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_LATCHED = 1'b1
  } state_t;

  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic [1:0][DB_W-1:0]  db_q, db_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0]            press_q, press_d;
  logic [1:0]            rel_q, rel_d;
  logic                  chord_q, chord_d;
  state_t                state_q, state_d;
  logic [1:0]            pressed;

  // Two-flop synchronizer; buttons are active-low so idle level is 1
  always_comb begin
    sync1_d = {BUT2, BUT1};
    sync2_d = sync1_q;
    pressed = ~sync2_q;
  end

  // Free-running prescaler; tick registered so it lines up with count == TICK_DIV-1
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
    tick_d  = (presc_d == PRESC_MAX);
  end

  // Per-button debounce: agreement clears the counter, disagreement counts ticks
  always_comb begin
    db_d    = db_q;
    lvl_d   = lvl_q;
    press_d = 2'b00;
    rel_d   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (pressed[i] == lvl_q[i]) begin
        db_d[i] = '0;
      end else if (tick_q) begin
        if (db_q[i] == DB_LAST) begin
          lvl_d[i]   = ~lvl_q[i];
          db_d[i]    = '0;
          press_d[i] = ~lvl_q[i];
          rel_d[i]   = lvl_q[i];
        end else begin
          db_d[i] = db_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Chord FSM next-state: one pulse per both-pressed episode, re-armed only when both released
  always_comb begin
    state_d = state_q;
    chord_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lvl_q == 2'b11) begin
          chord_d = 1'b1;
          state_d = S_LATCHED;
        end
      end
      S_LATCHED: begin
        if (lvl_q == 2'b00) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      presc_q <= '0;
      tick_q  <= 1'b0;
      db_q    <= '0;
      lvl_q   <= 2'b00;
      press_q <= 2'b00;
      rel_q   <= 2'b00;
      chord_q <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      db_q    <= db_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      chord_q <= chord_d;
      state_q <= state_d;
    end
  end

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  localparam int unsigned     HOLD_W   = $clog2(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  logic [1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]             long_q, long_d;

  // Hold counters: count ticks while pressed, fire once on reaching the limit, then saturate
  always_comb begin
    hold_d = hold_q;
    long_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!lvl_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_q && (hold_q[i] != HOLD_MAX)) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        long_d[i] = (hold_d[i] == HOLD_MAX);
      end
    end
  end

  // Long-press registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q <= '0;
      long_q <= 2'b00;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign BTN_LONG = long_q;
`else
  assign BTN_LONG = 2'b00;
`endif

  assign TICK      = tick_q;
  assign BTN_LVL   = lvl_q;
  assign BTN_PRESS = press_q;
  assign BTN_REL   = rel_q;
  assign CHORD     = chord_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8).
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BUT1;
  logic       BUT2;
  logic       TICK;
  logic [1:0] BTN_LVL;
  logic [1:0] BTN_PRESS;
  logic [1:0] BTN_REL;
  logic       CHORD;
  logic [1:0] BTN_LONG;

  button_conditioner #(
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    ,
    .LONG_TICKS   (8)
`endif
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BUT1      (BUT1),
    .BUT2      (BUT2),
    .TICK      (TICK),
    .BTN_LVL   (BTN_LVL),
    .BTN_PRESS (BTN_PRESS),
    .BTN_REL   (BTN_REL),
    .CHORD     (CHORD),
    .BTN_LONG  (BTN_LONG)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected event: output values plus an arrival window relative to a base cycle
  typedef struct {
    logic [1:0] press;
    logic [1:0] rel;
    logic       chord;
    logic [1:0] lng;
    logic [1:0] lvl;
    int         base;
    int         lo;
    int         hi;
    bit         rel_prev;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   last_ev = 0;

  task automatic push_ev(input logic [1:0] pr, input logic [1:0] rl, input logic ch,
                         input logic [1:0] lg, input logic [1:0] lv,
                         input int base, input int lo, input int hi, input bit relp);
    exp_t e;
    e.press = pr; e.rel = rl; e.chord = ch; e.lng = lg; e.lvl = lv;
    e.base = base; e.lo = lo; e.hi = hi; e.rel_prev = relp;
    q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Wait (bounded) for all expected events, then idle so stray events get noticed
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events still outstanding after %0d cycles", q.size(), budget);
      q.delete();
    end
    repeat (20) @(negedge CLK);
  endtask

  // Monitor: every cycle with an event output pops one expectation and compares
  always @(negedge CLK) begin
    exp_t e;
    int   b;
    int   dt;
    if (!RST && ((BTN_PRESS | BTN_REL | BTN_LONG) != 2'b00 || CHORD)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event@%0d: press=%b rel=%b chord=%b long=%b lvl=%b, want no event",
                 cyc, BTN_PRESS, BTN_REL, CHORD, BTN_LONG, BTN_LVL);
      end else begin
        e  = q.pop_front();
        b  = e.rel_prev ? last_ev : e.base;
        dt = cyc - b;
        if (BTN_PRESS !== e.press || BTN_REL !== e.rel || CHORD !== e.chord ||
            BTN_LONG !== e.lng || BTN_LVL !== e.lvl || dt < e.lo || dt > e.hi) begin
          errors++;
          $display("FAIL event@%0d: got press=%b rel=%b chord=%b long=%b lvl=%b dt=%0d, want press=%b rel=%b chord=%b long=%b lvl=%b dt in [%0d,%0d]",
                   cyc, BTN_PRESS, BTN_REL, CHORD, BTN_LONG, BTN_LVL, dt,
                   e.press, e.rel, e.chord, e.lng, e.lvl, e.lo, e.hi);
        end
      end
      last_ev = cyc;
    end
  end

  initial begin
    // 1: reset with both buttons held, then tick cadence
    RST = 1'b1; BUT1 = 1'b0; BUT2 = 1'b0;
    repeat (5) @(negedge CLK);
    check_val("rst_lvl",   BTN_LVL,   2'b00);
    check_val("rst_press", BTN_PRESS, 2'b00);
    check_val("rst_rel",   BTN_REL,   2'b00);
    check_val("rst_chord", {1'b0, CHORD}, 2'b00);
    check_val("rst_long",  BTN_LONG,  2'b00);
    check_val("rst_tick",  {1'b0, TICK},  2'b00);
    push_ev(2'b11, 2'b00, 1'b0, 2'b00, 2'b11, cyc, 11, 14, 1'b0);
    push_ev(2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 0, 1, 1, 1'b1);
    RST = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      check_val($sformatf("tick_%0d", k), {1'b0, TICK}, {1'b0, (k % 4) == 3});
    end
    drain(40);
    BUT1 = 1'b1; BUT2 = 1'b1;
    push_ev(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, cyc, 11, 14, 1'b0);
    drain(40);

    // 2: single press and release of button 1
    BUT1 = 1'b0;
    push_ev(2'b01, 2'b00, 1'b0, 2'b00, 2'b01, cyc, 11, 14, 1'b0);
    drain(40);
    BUT1 = 1'b1;
    push_ev(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, cyc, 11, 14, 1'b0);
    drain(40);

    // 3: bounce every 3 CLK never gets through
    for (int k = 0; k < 10; k++) begin
      BUT1 = 1'b0;
      repeat (3) @(negedge CLK);
      BUT1 = 1'b1;
      repeat (3) @(negedge CLK);
    end
    drain(1);
    check_val("bounce_lvl", BTN_LVL, 2'b00);

    // 4: chord, re-press of one button while other held, then a second chord
    BUT1 = 1'b0; BUT2 = 1'b0;
    push_ev(2'b11, 2'b00, 1'b0, 2'b00, 2'b11, cyc, 11, 14, 1'b0);
    push_ev(2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 0, 1, 1, 1'b1);
    drain(40);
    BUT1 = 1'b1;
    push_ev(2'b00, 2'b01, 1'b0, 2'b00, 2'b10, cyc, 11, 14, 1'b0);
    drain(40);
    BUT1 = 1'b0;
    push_ev(2'b01, 2'b00, 1'b0, 2'b00, 2'b11, cyc, 11, 14, 1'b0);
    drain(40);
    BUT1 = 1'b1; BUT2 = 1'b1;
    push_ev(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, cyc, 11, 14, 1'b0);
    drain(40);
    BUT1 = 1'b0; BUT2 = 1'b0;
    push_ev(2'b11, 2'b00, 1'b0, 2'b00, 2'b11, cyc, 11, 14, 1'b0);
    push_ev(2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 0, 1, 1, 1'b1);
    drain(40);
    BUT1 = 1'b1; BUT2 = 1'b1;
    push_ev(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, cyc, 11, 14, 1'b0);
    drain(40);

    // 5: long hold of button 2
    BUT2 = 1'b0;
    push_ev(2'b10, 2'b00, 1'b0, 2'b00, 2'b10, cyc, 11, 14, 1'b0);
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    push_ev(2'b00, 2'b00, 1'b0, 2'b10, 2'b10, 0, 28, 36, 1'b1);
`endif
    repeat (60) @(negedge CLK);
    check_val("long_quiet", BTN_LONG, 2'b00);
    BUT2 = 1'b1;
    push_ev(2'b00, 2'b10, 1'b0, 2'b00, 2'b00, cyc, 11, 14, 1'b0);
    drain(40);

    // 6: reset while both held re-runs debounce and chord
    BUT1 = 1'b0; BUT2 = 1'b0;
    push_ev(2'b11, 2'b00, 1'b0, 2'b00, 2'b11, cyc, 11, 14, 1'b0);
    push_ev(2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 0, 1, 1, 1'b1);
    drain(40);
    check_val("held_lvl", BTN_LVL, 2'b11);
    RST = 1'b1;
    #1;
    check_val("mid_rst_lvl",   BTN_LVL,   2'b00);
    check_val("mid_rst_press", BTN_PRESS, 2'b00);
    check_val("mid_rst_chord", {1'b0, CHORD}, 2'b00);
    check_val("mid_rst_tick",  {1'b0, TICK},  2'b00);
    repeat (2) @(negedge CLK);
    push_ev(2'b11, 2'b00, 1'b0, 2'b00, 2'b11, cyc, 11, 14, 1'b0);
    push_ev(2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 0, 1, 1, 1'b1);
    RST = 1'b0;
    drain(40);
    BUT1 = 1'b1; BUT2 = 1'b1;
    push_ev(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, cyc, 11, 14, 1'b0);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
